// File: rtl/mem_stage_pkg.sv
// Shared encodings for the RISC-V memory stage: writeback selects, load/store
// size codes, FSM states and the MEM/WB register layout.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [31:0] pc4;
    logic [4:0]  w_idx;
    logic [1:0]  wb_sel;
    logic        wb_en;
  } wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port. The memory stage drives the request side (master),
// the memory model or cache answers with ack and read data (slave).
interface mem_stage_if;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
    input  i_dmem_ack, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
    output i_dmem_ack, i_dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: store byte enables / replicated write data, load lane
// extraction with sign/zero extension, and the misaligned-access check.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  func3_i,
  input  logic        is_store_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] lane;

  always_comb begin
    misaligned_o = 1'b0;
    be_o         = 4'b1111;
    wdata_o      = 32'h0;
    load_data_o  = 32'h0;
    lane         = rdata_i >> {addr_lo_i, 3'b000};

    // func3[1:0] carries the size; func3[2] selects zero extension on loads
    unique case (func3_i[1:0])
      2'b00: begin
        if (is_store_i) begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{rs2_i[7:0]}};
        end
        load_data_o = func3_i[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        misaligned_o = addr_lo_i[0];
        if (is_store_i) begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{rs2_i[15:0]}};
        end
        load_data_o = func3_i[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
      default: begin
        misaligned_o = |addr_lo_i;
        if (is_store_i) wdata_o = rs2_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory stage: issues loads/stores on the req/ack port, stalls upstream
// while waiting (bounded by TIMEOUT), and registers results into MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_alu_res,
  input  logic [31:0] i_rs2,
  input  logic        i_mem_w_en,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_pc4,
  input  logic [4:0]  i_w_idx,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_wb_en,
  output logic [31:0] o_mem_fw_data,
  output logic        o_stall,
  mem_stage_if.master dmem,
  output logic [31:0] o_alu_res,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_pc4,
  output logic [4:0]  o_w_idx,
  output logic [1:0]  o_wb_sel,
  output logic        o_wb_en,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  wb_t           wb_q;
  logic          misaligned_q, bus_err_q;

  logic        is_load, is_store, mem_op, misaligned, req, timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;

  assign is_load  = i_wb_en && (i_wb_sel == WB_MEM);
  assign is_store = i_mem_w_en;
  assign mem_op   = is_load || is_store;

  lsu_align u_align (
    .addr_lo_i    (i_alu_res[1:0]),
    .func3_i      (i_func3),
    .is_store_i   (is_store),
    .rs2_i        (i_rs2),
    .rdata_i      (dmem.i_dmem_rdata),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data),
    .misaligned_o (misaligned)
  );

  // In WAIT the upstream registers are frozen, so the live inputs are the held op
  assign req = !rst && ((state_q == ST_IDLE && mem_op && !misaligned) || state_q == ST_WAIT);
  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT));

  assign o_stall       = req && !dmem.i_dmem_ack && !timeout_hit;
  assign o_mem_fw_data = (i_wb_sel == WB_PC4) ? i_pc4 : i_alu_res;

  assign dmem.o_dmem_req   = req;
  assign dmem.o_dmem_we    = req && is_store;
  assign dmem.o_dmem_addr  = req ? {i_alu_res[31:2], 2'b00} : 32'h0;
  assign dmem.o_dmem_be    = req ? be : 4'h0;
  assign dmem.o_dmem_wdata = req ? wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wb_q         <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      // Every cycle captures the op; wb_en alone decides whether it retires
      wb_q.alu_res  <= i_alu_res;
      wb_q.pc4      <= i_pc4;
      wb_q.w_idx    <= i_w_idx;
      wb_q.wb_sel   <= i_wb_sel;
      wb_q.mem_data <= 32'h0;
      wb_q.wb_en    <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_err_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!mem_op) begin
            wb_q.wb_en <= i_wb_en;
          end else if (misaligned) begin
            misaligned_q <= 1'b1;
          end else if (dmem.i_dmem_ack) begin
            wb_q.wb_en    <= i_wb_en;
            wb_q.mem_data <= is_load ? load_data : 32'h0;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (dmem.i_dmem_ack) begin
            wb_q.wb_en    <= i_wb_en;
            wb_q.mem_data <= is_load ? load_data : 32'h0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_alu_res    = wb_q.alu_res;
  assign o_mem_data   = wb_q.mem_data;
  assign o_pc4        = wb_q.pc4;
  assign o_w_idx      = wb_q.w_idx;
  assign o_wb_sel     = wb_q.wb_sel;
  assign o_wb_en      = wb_q.wb_en;
  assign o_misaligned = misaligned_q;
  assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written wait/timeout/reset
// sequences, and randomized ops checked against a behavioural model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_alu_res, i_rs2, i_pc4;
  logic        i_mem_w_en, i_wb_en;
  logic [2:0]  i_func3;
  logic [4:0]  i_w_idx;
  logic [1:0]  i_wb_sel;
  logic [31:0] o_mem_fw_data, o_alu_res, o_mem_data, o_pc4;
  logic        o_stall, o_wb_en, o_misaligned, o_bus_err;
  logic [4:0]  o_w_idx;
  logic [1:0]  o_wb_sel;

  int n_chk = 0;
  int n_fail = 0;

  mem_stage_if dif ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_alu_res     (i_alu_res),
    .i_rs2         (i_rs2),
    .i_mem_w_en    (i_mem_w_en),
    .i_func3       (i_func3),
    .i_pc4         (i_pc4),
    .i_w_idx       (i_w_idx),
    .i_wb_sel      (i_wb_sel),
    .i_wb_en       (i_wb_en),
    .o_mem_fw_data (o_mem_fw_data),
    .o_stall       (o_stall),
    .dmem          (dif.master),
    .o_alu_res     (o_alu_res),
    .o_mem_data    (o_mem_data),
    .o_pc4         (o_pc4),
    .o_w_idx       (o_w_idx),
    .o_wb_sel      (o_wb_sel),
    .o_wb_en       (o_wb_en),
    .o_misaligned  (o_misaligned),
    .o_bus_err     (o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic mw,
                       input logic [2:0] f3, input logic [1:0] sel, input logic wen,
                       input logic [4:0] widx, input logic [31:0] pc4);
    i_alu_res = alu; i_rs2 = rs2; i_mem_w_en = mw; i_func3 = f3;
    i_wb_sel = sel; i_wb_en = wen; i_w_idx = widx; i_pc4 = pc4;
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [31:0] v;
    int          x;
    v = rd >> (8 * int'(lo));
    case (f3)
      3'b000:  begin x = $signed(v[7:0]);  return 32'(x); end
      3'b001:  begin x = $signed(v[15:0]); return 32'(x); end
      3'b100:  return v & 32'hFF;
      3'b101:  return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic st, input logic [1:0] lo, input logic [2:0] f3);
    if (!st) return 4'hF;
    case (f3[1:0])
      2'b00:   return 4'(1 << lo);
      2'b01:   return 4'(3 << lo);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return (rs2 & 32'hFF) * 32'h0101_0101;
      2'b01:   return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // One op from the cycle it is presented until it retires, times out or is dropped.
  // delay = cycle (0-based) on which ack is raised.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic mw,
                        input logic [2:0] f3, input logic [1:0] sel, input logic wen,
                        input logic [4:0] widx, input logic [31:0] pc4, input int delay,
                        output int stalls);
    logic        ld, mem, mis, ackv;
    logic [1:0]  lo;
    logic [31:0] rd;
    stalls = 0;
    drive(alu, rs2, mw, f3, sel, wen, widx, pc4);
    lo  = alu[1:0];
    ld  = wen && sel == 2'b01;
    mem = ld || mw;
    mis = mem && ((f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00));
    if (!mem || mis) begin
      dif.i_dmem_ack = 1'($urandom_range(0, 1));
      dif.i_dmem_rdata = $urandom;
      #1;
      chk("r_noreq", 32'(dif.o_dmem_req), 32'd0);
      chk("r_nostall", 32'(o_stall), 32'd0);
      chk("r_fw", o_mem_fw_data, (sel == 2'b10) ? pc4 : alu);
      @(posedge clk); #1;
      chk("r_wben", 32'(o_wb_en), mem ? 32'd0 : 32'(wen));
      chk("r_mis", 32'(o_misaligned), 32'(mis));
      chk("r_alu", o_alu_res, alu);
      chk("r_widx", 32'(o_w_idx), 32'(widx));
      @(negedge clk);
    end else begin
      for (int c = 0; c <= TO + 2; c++) begin
        ackv = (c == delay);
        rd = $urandom;
        dif.i_dmem_ack = ackv;
        dif.i_dmem_rdata = rd;
        #1;
        chk("r_req", 32'(dif.o_dmem_req), 32'd1);
        chk("r_we", 32'(dif.o_dmem_we), 32'(mw));
        chk("r_addr", dif.o_dmem_addr, alu & 32'hFFFF_FFFC);
        chk("r_be", 32'(dif.o_dmem_be), 32'(ref_be(mw, lo, f3)));
        if (mw) chk("r_wdata", dif.o_dmem_wdata, ref_wdata(rs2, f3));
        chk("r_stall", 32'(o_stall), 32'(!ackv && c < TO));
        if (o_stall) stalls++;
        @(posedge clk); #1;
        if (ackv) begin
          chk("r_done_wben", 32'(o_wb_en), 32'(wen));
          if (ld) chk("r_ldata", o_mem_data, ref_load(rd, lo, f3));
          chk("r_done_err", 32'(o_bus_err), 32'd0);
          @(negedge clk);
          break;
        end else if (c == TO) begin
          chk("r_to_err", 32'(o_bus_err), 32'd1);
          chk("r_to_wben", 32'(o_wb_en), 32'd0);
          @(negedge clk);
          break;
        end else begin
          chk("r_bubble", 32'(o_wb_en), 32'd0);
          chk("r_bub_err", 32'(o_bus_err), 32'd0);
        end
        @(negedge clk);
        if (c == TO + 2) chk("r_bound", 32'd1, 32'd0);
      end
      dif.i_dmem_ack = 1'b0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] alu, rs2, pc4, rdata;
    logic        mw, wen, ack;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [4:0]  widx;
    logic        e_req, e_stall, e_wben, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_fw, e_mdata;
  } vec_t;

  vec_t vt[$];

  initial begin
    int st;
    vec_t v;

    dif.i_dmem_ack = 1'b0;
    dif.i_dmem_rdata = 32'h0;
    drive(32'h0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wben", 32'(o_wb_en), 32'd0);
    chk("rst_alu", o_alu_res, 32'd0);
    chk("rst_mdata", o_mem_data, 32'd0);
    chk("rst_err", 32'(o_bus_err | o_misaligned), 32'd0);
    chk("rst_req", 32'(dif.o_dmem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //        name   alu           rs2           pc4        rdata         mw wen ack f3      sel    widx req stl wben mis be       wdata         fw            mdata
    vt.push_back('{"alu",    32'h1234, 32'h0, 32'h100, 32'h0, 0,1,0, 3'b000, 2'b00, 5'd5, 0,0,1,0, 4'h0, 32'h0, 32'h1234, 32'h0});
    vt.push_back('{"lb",     32'h103, 32'h0, 32'h0, 32'h80AABBCC, 0,1,1, 3'b000, 2'b01, 5'd7, 1,0,1,0, 4'hF, 32'h0, 32'h103, 32'hFFFFFF80});
    vt.push_back('{"lbu",    32'h103, 32'h0, 32'h0, 32'h80AABBCC, 0,1,1, 3'b100, 2'b01, 5'd7, 1,0,1,0, 4'hF, 32'h0, 32'h103, 32'h00000080});
    vt.push_back('{"lw_mis", 32'h6, 32'h0, 32'h0, 32'h0, 0,1,0, 3'b010, 2'b01, 5'd3, 0,0,0,1, 4'h0, 32'h0, 32'h6, 32'h0});
    vt.push_back('{"lh",     32'h102, 32'h0, 32'h0, 32'h80AABBCC, 0,1,1, 3'b001, 2'b01, 5'd9, 1,0,1,0, 4'hF, 32'h0, 32'h102, 32'hFFFF80AA});
    vt.push_back('{"lhu",    32'h100, 32'h0, 32'h0, 32'h80AABBCC, 0,1,1, 3'b101, 2'b01, 5'd9, 1,0,1,0, 4'hF, 32'h0, 32'h100, 32'h0000BBCC});
    vt.push_back('{"sb",     32'h201, 32'h12345678, 32'h0, 32'h0, 1,0,1, 3'b000, 2'b00, 5'd0, 1,0,0,0, 4'b0010, 32'h78787878, 32'h201, 32'h0});
    vt.push_back('{"sw",     32'h300, 32'hCAFEF00D, 32'h0, 32'h0, 1,0,1, 3'b010, 2'b00, 5'd0, 1,0,0,0, 4'hF, 32'hCAFEF00D, 32'h300, 32'h0});
    vt.push_back('{"jal",    32'h999, 32'h0, 32'h44, 32'h0, 0,1,0, 3'b000, 2'b10, 5'd1, 0,0,1,0, 4'h0, 32'h0, 32'h44, 32'h0});
    vt.push_back('{"sh_mis", 32'h203, 32'hDEADBEEF, 32'h0, 32'h0, 1,0,0, 3'b001, 2'b00, 5'd0, 0,0,0,1, 4'h0, 32'h0, 32'h203, 32'h0});

    foreach (vt[k]) begin
      v = vt[k];
      drive(v.alu, v.rs2, v.mw, v.f3, v.sel, v.wen, v.widx, v.pc4);
      dif.i_dmem_ack = v.ack;
      dif.i_dmem_rdata = v.rdata;
      #1;
      chk({v.name, "_req"}, 32'(dif.o_dmem_req), 32'(v.e_req));
      chk({v.name, "_stall"}, 32'(o_stall), 32'(v.e_stall));
      chk({v.name, "_be"}, 32'(dif.o_dmem_be), 32'(v.e_be));
      chk({v.name, "_wdata"}, dif.o_dmem_wdata, v.e_wdata);
      chk({v.name, "_fw"}, o_mem_fw_data, v.e_fw);
      @(posedge clk); #1;
      chk({v.name, "_wben"}, 32'(o_wb_en), 32'(v.e_wben));
      chk({v.name, "_mdata"}, o_mem_data, v.e_mdata);
      chk({v.name, "_mis"}, 32'(o_misaligned), 32'(v.e_mis));
      chk({v.name, "_widx"}, 32'(o_w_idx), 32'(v.widx));
      @(negedge clk);
    end
    dif.i_dmem_ack = 1'b0;

    // SH with ack on the fourth cycle: three stall cycles, store retires with wb_en=0
    run_op(32'h202, 32'hDEADBEEF, 1'b1, 3'b001, 2'b00, 1'b0, 5'd0, 32'h0, 3, st);
    chk("sh_wait_stalls", 32'(st), 32'd3);

    // LW that never gets an ack, then an ALU op must retire normally
    run_op(32'h400, 32'h0, 1'b0, 3'b010, 2'b01, 1'b1, 5'd4, 32'h0, 99, st);
    chk("to_stalls", 32'(st), 32'(TO));
    run_op(32'h55, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 5'd6, 32'h0, 0, st);

    // Reset while waiting drops the request immediately; a late ack is ignored
    drive(32'h500, 32'h0, 1'b0, 3'b010, 2'b01, 1'b1, 5'd8, 32'h0);
    dif.i_dmem_ack = 1'b0;
    #1;
    chk("rw_stall0", 32'(o_stall), 32'd1);
    @(negedge clk);
    #1;
    chk("rw_req_wait", 32'(dif.o_dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_req_rst", 32'(dif.o_dmem_req), 32'd0);
    chk("rw_stall_rst", 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    chk("rw_wben", 32'(o_wb_en), 32'd0);
    chk("rw_alu", o_alu_res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h77, 32'h0, 1'b0, 3'b000, 2'b00, 1'b0, 5'd2, 32'h0);
    dif.i_dmem_ack = 1'b1;
    #1;
    chk("stray_req", 32'(dif.o_dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("stray_wben", 32'(o_wb_en), 32'd0);
    chk("stray_err", 32'(o_bus_err), 32'd0);
    @(negedge clk);
    dif.i_dmem_ack = 1'b0;

    // Randomized ops against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  f3;
      logic [1:0]  sel;
      logic        mw, wen;
      int          kind;
      logic [2:0]  ldf[5];
      ldf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        mw = 1'b0; wen = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 1) ? 2'b10 : 2'b00; f3 = 3'($urandom_range(0, 7));
      end else if (kind == 1) begin
        mw = 1'b0; wen = 1'b1; sel = 2'b01; f3 = ldf[$urandom_range(0, 4)];
      end else begin
        mw = 1'b1; wen = 1'b0; sel = 2'b00; f3 = 3'($urandom_range(0, 2));
      end
      run_op($urandom, $urandom, mw, f3, sel, wen, 5'($urandom), $urandom,
             $urandom_range(0, TO + 2), st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
